// File: rtl/inst_sequencer_pkg.sv
// Shared CPU package: sequencer state encoding, default parameters and widths.
package inst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC0 = 2'd1,
        ST_EXEC1 = 2'd2,
        ST_INT   = 2'd3
    } state_t;

    localparam logic [7:0]  NOP_INST_DEF    = 8'h00;
    localparam int unsigned ACK_TIMEOUT_DEF = 15;
    localparam int unsigned TIMER_W         = 8;

endpackage

// File: rtl/inst_sequencer_fetch_timer.sv
// Fetch wait-cycle counter; flags the cycle in which the wait budget runs out.
module fetch_timer
    import inst_sequencer_pkg::*;
#(
    parameter int unsigned TERM = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc_c
);

    logic [TIMER_W-1:0] r_cnt;

    assign o_tc_c = i_en && (r_cnt == TIMER_W'(TERM - 1));

    // Terminal count wraps back to zero so the next fetch attempt starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc_c) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetch, one- or two-cycle execute, interrupt entry.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter logic [7:0]  NOP_INST    = NOP_INST_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    input  logic       stall,
    input  logic       irq,
    input  logic       ie_set,
    input  logic       ie_clr,
    output logic       mem_req,
    output logic       pc_inc,
    output logic [7:0] inst,
    output logic       cycle,
    output logic       commit,
    output logic       int_take,
    output logic       fault
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_inst;
    logic [7:0] w_inst_nxt;
    logic       r_ie;
    logic       w_ie_nxt;
    logic       r_fault;
    logic       r_run;
    logic       w_end;
    logic       w_timer_en;
    logic       w_timer_clr;
    logic       w_timer_tc;

    fetch_timer #(
        .TERM (ACK_TIMEOUT)
    ) u_fetch_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_timer_en),
        .i_clr  (w_timer_clr),
        .o_tc_c (w_timer_tc)
    );

    // r_run keeps requests and strobes quiet until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_inst  <= NOP_INST;
            r_ie    <= 1'b0;
            r_fault <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_inst  <= w_inst_nxt;
            r_ie    <= w_ie_nxt;
            r_fault <= r_fault | w_timer_tc;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inst_nxt  = r_inst;
        w_end       = 1'b0;
        w_timer_en  = 1'b0;
        w_timer_clr = 1'b1;
        mem_req     = 1'b0;
        pc_inc      = 1'b0;
        cycle       = 1'b0;
        commit      = 1'b0;
        int_take    = 1'b0;

        if (r_run) begin
            unique case (r_state)
                ST_FETCH: begin
                    mem_req     = 1'b1;
                    w_timer_en  = !mem_ack;
                    w_timer_clr = mem_ack;
                    if (mem_ack) begin
                        pc_inc      = 1'b1;
                        w_inst_nxt  = mem_rdata;
                        w_state_nxt = ST_EXEC0;
                    end
                end
                ST_EXEC0: begin
                    if (!stall) begin
                        if (r_inst[7]) begin
                            w_state_nxt = ST_EXEC1;
                        end else begin
                            w_end = 1'b1;
                        end
                    end
                end
                ST_EXEC1: begin
                    cycle = 1'b1;
                    w_end = !stall;
                end
                ST_INT: begin
                    int_take    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end

        // irq is only looked at here, on the final execute cycle.
        if (w_end) begin
            commit      = 1'b1;
            w_inst_nxt  = NOP_INST;
            w_state_nxt = (irq && r_ie) ? ST_INT : ST_FETCH;
        end

        if (int_take || ie_clr) begin
            w_ie_nxt = 1'b0;
        end else if (ie_set) begin
            w_ie_nxt = 1'b1;
        end else begin
            w_ie_nxt = r_ie;
        end
    end

    assign inst  = r_inst;
    assign fault = r_fault;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: randomized instruction stream vs a transaction model.
module tb_inst_sequencer;

    localparam int unsigned ACK_TO = 15;
    localparam logic [7:0]  NOP    = 8'h00;

    logic       clk;
    logic       rst;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       stall;
    logic       irq;
    logic       ie_set;
    logic       ie_clr;
    logic       mem_req;
    logic       pc_inc;
    logic [7:0] inst;
    logic       cycle;
    logic       commit;
    logic       int_take;
    logic       fault;

    inst_sequencer #(
        .NOP_INST    (NOP),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .irq       (irq),
        .ie_set    (ie_set),
        .ie_clr    (ie_clr),
        .mem_req   (mem_req),
        .pc_inc    (pc_inc),
        .inst      (inst),
        .cycle     (cycle),
        .commit    (commit),
        .int_take  (int_take),
        .fault     (fault)
    );

    typedef struct {
        int kind;   // 1 = pc_inc, 2 = commit, 3 = int_take
        int stamp;
    } ev_t;

    ev_t        q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_n = 0;
    bit         chk_en = 0;
    bit         rnd_ie = 0;
    bit         set_force = 0;
    logic       exp_req, exp_cyc, exp_fault;
    logic [7:0] exp_inst;
    bit         m_ie = 0;
    bit         m_fault = 0;
    int         m_wait = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Per-cycle output checks plus in-order event scoreboard.
    always @(negedge clk) begin : monitor
        int  n_str;
        int  kind;
        ev_t e;
        if (chk_en) begin
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("cycle", 32'(cycle), 32'(exp_cyc));
            check("inst", 32'(inst), 32'(exp_inst));
            check("fault", 32'(fault), 32'(exp_fault));
            n_str = int'(pc_inc) + int'(commit) + int'(int_take);
            check("strobes_exclusive", 32'(n_str <= 1), 32'd1);
            if (n_str != 0) begin
                kind = pc_inc ? 1 : (commit ? 2 : 3);
                if (q.size() == 0) begin
                    check("unexpected_event", 32'(kind), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    check("event_cycle", 32'(cyc_n), 32'(e.stamp));
                end
            end
        end
    end

    task automatic push(input int kind);
        q.push_back('{kind: kind, stamp: cyc_n});
    endtask

    // One clock of stimulus; model ie and the fetch wait budget advance at its edge.
    task automatic step(input logic ack, input logic [7:0] rd, input logic st, input logic ir,
                        input bit fwait, input bit is_int,
                        input logic e_req, input logic e_cyc, input logic [7:0] e_inst);
        mem_ack   = ack;
        mem_rdata = rd;
        stall     = st;
        irq       = ir;
        ie_set    = set_force || (rnd_ie && $urandom_range(0, 7) == 0);
        ie_clr    = rnd_ie && $urandom_range(0, 9) == 0;
        set_force = 0;
        exp_req   = e_req;
        exp_cyc   = e_cyc;
        exp_inst  = e_inst;
        exp_fault = m_fault;
        chk_en    = 1;
        @(posedge clk);
        m_ie = is_int ? 1'b0 : (ie_clr ? 1'b0 : (ie_set ? 1'b1 : m_ie));
        if (fwait && !ack) begin
            m_wait++;
            if (m_wait == int'(ACK_TO)) begin
                m_fault = 1;
                m_wait  = 0;
            end
        end else begin
            m_wait = 0;
        end
        #1;
    endtask

    // One instruction: w wait cycles, fetch of d, s0/s1 stalls, irq level on the final cycle.
    task automatic do_instr(input int w, input logic [7:0] d, input int s0, input int s1,
                            input logic ir_end, input bit set_first);
        bit take;
        set_force = set_first;
        for (int i = 0; i < w; i++)
            step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1, 0, 1'b1, 1'b0, NOP);
        push(1);
        step(1'b1, d, 1'($urandom), 1'($urandom), 1, 0, 1'b1, 1'b0, NOP);
        for (int i = 0; i < s0; i++)
            step(1'($urandom), 8'($urandom), 1'b1, 1'($urandom), 0, 0, 1'b0, 1'b0, d);
        if (d[7]) begin
            step(1'($urandom), 8'($urandom), 1'b0, 1'($urandom), 0, 0, 1'b0, 1'b0, d);
            for (int i = 0; i < s1; i++)
                step(1'($urandom), 8'($urandom), 1'b1, 1'($urandom), 0, 0, 1'b0, 1'b1, d);
        end
        take = ir_end && m_ie;
        push(2);
        step(1'($urandom), 8'($urandom), 1'b0, ir_end, 0, 0, 1'b0, d[7], d);
        if (take) begin
            push(3);
            step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0, 1, 1'b0, 1'b0, NOP);
        end
    endtask

    // Hold reset for an edge, check quiet outputs, release and step to the first live edge.
    task automatic reset_seq();
        chk_en  = 0;
        mem_ack = 0; stall = 0; irq = 0; ie_set = 0; ie_clr = 0; mem_rdata = 8'h00;
        rst     = 1;
        #1;
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_pc_inc", 32'(pc_inc), 32'd0);
        check("rst_int_take", 32'(int_take), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_inst", 32'(inst), 32'(NOP));
        check("rst_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_mem_req", 32'(mem_req), 32'd0);
        rst = 0;
        #1;
        check("release_mem_req", 32'(mem_req), 32'd0);
        q.delete();
        m_ie = 0; m_fault = 0; m_wait = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        mem_ack = 0; stall = 0; irq = 0; ie_set = 0; ie_clr = 0; mem_rdata = 8'h00;
        @(posedge clk);
        #1;
        reset_seq();

        // Single-cycle op, ack in the first fetch cycle.
        do_instr(0, 8'h3A, 0, 0, 1'b0, 0);
        // Two-cycle op.
        do_instr(1, 8'h85, 0, 0, 1'b0, 0);
        // Three stall cycles in EXEC1.
        do_instr(0, 8'h90, 0, 3, 1'b0, 0);
        // Interrupt taken once, then refused until ie is set again.
        do_instr(1, 8'h01, 0, 0, 1'b1, 1);
        do_instr(0, 8'h01, 0, 0, 1'b1, 0);
        do_instr(0, 8'h01, 0, 0, 1'b1, 1);

        // Fetch timeout: no ack for 20 cycles, then a normal fetch.
        for (int i = 0; i < 20; i++)
            step(1'b0, 8'($urandom), 1'($urandom), 1'b0, 1, 0, 1'b1, 1'b0, NOP);
        do_instr(0, 8'h85, 1, 1, 1'b0, 0);

        rnd_ie = 1;
        for (int k = 0; k < 150; k++)
            do_instr($urandom_range(0, 4), 8'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1'($urandom), 0);

        // Reset in the middle of EXEC1: no commit, fault cleared.
        rnd_ie = 0;
        push(1);
        step(1'b1, 8'h90, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, NOP);
        step(1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'h90);
        step(1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 8'h90);
        check("pre_reset_pending", 32'(q.size()), 32'd0);
        reset_seq();

        rnd_ie = 1;
        for (int k = 0; k < 100; k++)
            do_instr($urandom_range(0, 4), 8'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1'($urandom), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, NOP);
        chk_en = 0;
        check("events_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter NOP_INST, default 8'h00, the instruction presented on inst while no valid instruction is held.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, the maximum wait cycles for mem_ack before fault (range 1..255).
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 mem_rdata  in  8  instruction byte from memory, valid when mem_ack=1.
REQ-006 mem_ack  in  1  memory completes fetch this cycle.
REQ-007 stall  in  1  datapath hold request; freezes execute progress.
REQ-008 irq  in  1  level interrupt request.
REQ-009 ie_set / ie_clr  in  1 each  interrupt-enable set / clear strobes.
REQ-010 mem_req  out  1  fetch request to memory.
REQ-011 pc_inc  out  1  one-cycle PC increment strobe.
REQ-012 inst  out  8  held instruction byte, fed to the control decoder.
REQ-013 cycle  out  1  execute phase to control decoder: 0 = first, 1 = second.
REQ-014 commit  out  1  one-cycle strobe on the final execute cycle of an instruction.
REQ-015 int_take  out  1  one-cycle interrupt-entry strobe.
REQ-016 fault  out  1  sticky fetch-timeout flag.

Function
REQ-017 States SHALL be FETCH, EXEC0, EXEC1, INT.
REQ-018 FETCH: mem_req=1, cycle=0, inst=NOP_INST; on mem_ack, inst register loads mem_rdata, pc_inc pulses that same cycle, and the next state is EXEC0.
REQ-019 FETCH SHALL count wait cycles; when mem_ack is still 0 after ACK_TIMEOUT wait cycles, fault SHALL set, the counter SHALL clear and FETCH SHALL restart (mem_req stays 1).
REQ-020 EXEC0: cycle=0; if stall=1, the state SHALL be held; otherwise, when inst[7]=1, the next state is EXEC1; when inst[7]=0, commit pulses and the instruction ends.
REQ-021 EXEC1: cycle=1; if stall=1, the state SHALL be held; otherwise commit pulses and the instruction ends.
REQ-022 At instruction end, if irq=1 and ie=1, the next state SHALL be INT, otherwise FETCH.
REQ-023 INT SHALL last one cycle: int_take=1, ie clears, and the next state is FETCH.
REQ-024 ie SHALL update every cycle; ie_clr SHALL have priority over ie_set; clearing in INT SHALL override both.
REQ-025 irq SHALL be sampled only at instruction end; irq pulses that drop before instruction end SHALL be ignored.
REQ-026 commit, pc_inc and int_take SHALL be mutually exclusive, and each SHALL be 1 for exactly one cycle per event.
REQ-027 stall SHALL have no effect in FETCH or INT.
REQ-028 inst SHALL remain constant from EXEC0 entry through instruction end.
REQ-029 Timeout counter width SHALL be 8 bits; it SHALL clear on mem_ack and on leaving FETCH.

Reset
REQ-030 While rst=1, the state SHALL be FETCH, inst register = NOP_INST, ie=0, fault=0, counter=0.
REQ-031 While rst=1, all strobes SHALL be 0 and mem_req SHALL be 0; mem_req SHALL assert on the first clk edge after rst deasserts.
REQ-032 A reset asserted mid-instruction SHALL abort it with no commit.

Structure
REQ-033 State encoding and the NOP_INST and ACK_TIMEOUT defaults SHALL live in the shared CPU package.
REQ-034 The timeout counter SHALL be a sub-module named fetch_timer (enable, clear, terminal-count output).

Verification
REQ-035 Single-cycle op: ack in the first FETCH cycle with rdata=8'h3A -> pc_inc at t0, EXEC0 at t1 with cycle=0 and commit=1, mem_req=1 at t2.
REQ-036 Two-cycle op: rdata=8'h85 -> EXEC0 with cycle=0 and commit=0, then EXEC1 with cycle=1 and commit=1; inst=8'h85 throughout.
REQ-037 Stall: rdata=8'h90 with stall=1 for 3 cycles in EXEC1 -> cycle=1 held for 4 cycles, then one commit pulse.
REQ-038 Interrupt: ie_set, then irq=1 during EXEC0 of 8'h01 -> int_take in the cycle after commit, ie=0, then FETCH; a second irq is not taken until ie_set.
REQ-039 Timeout: mem_ack held 0 -> fault=1 after exactly 15 wait cycles, mem_req stays 1; a later ack proceeds normally with fault still 1.
REQ-040 Reset mid-EXEC1: rst pulse -> inst=8'h00, no commit, fault=0, mem_req=1 on the first edge after release.
